// File: rtl/chart_sequencer.sv
// Chart sequencer: walks a delta/lane-mask chart ROM and fires note spawn pulses on the tick grid.
// Optional build macro CHART_LOOP_EN: the end marker restarts the chart from address 0 instead of finishing.
module chart_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DELTA_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 tick,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DELTA_W+3:0]   rom_data,
  output logic                 spawn_green,
  output logic                 spawn_yellow,
  output logic                 spawn_blue,
  output logic                 spawn_orange,
  output logic                 spawn_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DELTA_W-1:0]   count_q, count_d;
  logic [3:0]           mask_q, mask_d;

  logic [DELTA_W-1:0]   rom_delta;
  logic [3:0]           rom_mask;
  logic                 end_marker;
  logic                 addr_last;
  logic                 tick_ok;

  assign rom_delta  = rom_data[DELTA_W+3:4];
  assign rom_mask   = rom_data[3:0];
  assign end_marker = (rom_delta == '0) && (rom_mask == '0);
  assign addr_last  = (addr_q == {ADDR_W{1'b1}});
  assign tick_ok    = tick && !pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // The latched lane mask only reaches the outputs in EMIT, so it needs no reset.
  always_ff @(posedge clk) begin
    mask_q <= mask_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (end_marker) begin
`ifdef CHART_LOOP_EN
          addr_d  = '0;
          state_d = S_FETCH;
`else
          state_d = S_DONE;
`endif
        end else begin
          count_d = rom_delta;
          mask_d  = rom_mask;
          state_d = (rom_delta == '0) ? S_EMIT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick_ok) begin
          count_d = count_q - DELTA_W'(1);
          if (count_q == DELTA_W'(1)) state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // The last ROM word ends the chart rather than wrapping to address 0.
        if (addr_last) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spawn_green  = 1'b0;
    spawn_yellow = 1'b0;
    spawn_blue   = 1'b0;
    spawn_orange = 1'b0;
    spawn_valid  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_FETCH, S_LOAD, S_WAIT: busy = 1'b1;
      S_EMIT: begin
        busy         = 1'b1;
        spawn_green  = mask_q[3];
        spawn_yellow = mask_q[2];
        spawn_blue   = mask_q[1];
        spawn_orange = mask_q[0];
        spawn_valid  = |mask_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr = addr_q;

endmodule
